// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: zero-latency register scoreboard; define SCOREBOARD_WB_BYPASS_EN for same-cycle writeback bypass
module regfile_scoreboard #(
  parameter int XLEN              = 32,
  parameter int REG_FILE_DEPTH    = 32,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0] rs1,
  input  logic [REG_FILE_ADDR_LEN-1:0] rs2,
  input  logic [REG_FILE_ADDR_LEN-1:0] rd,
  input  logic                         rs1_used,
  input  logic                         rs2_used,
  input  logic                         rd_wen,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  input  logic                         wb_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0] wb_rd,
  output logic [REG_FILE_DEPTH-1:0]    busy_vec,
  output logic [REG_FILE_ADDR_LEN:0]   pending_cnt,
  output logic                         wb_err
);
  localparam logic [REG_FILE_DEPTH-1:0] ONE = {{(REG_FILE_DEPTH-1){1'b0}}, 1'b1};

  if (XLEN < 1) begin : g_bad_xlen
    $error("XLEN must be positive");
  end

  logic [REG_FILE_DEPTH-1:0]  busy_eff, set_vec, clr_vec, busy_nxt;
  logic [REG_FILE_ADDR_LEN:0] cnt_nxt;
  logic                       hazard, fire, err_nxt;

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign busy_eff = busy_vec & ~(wb_valid ? ONE << wb_rd : '0);
`else
  assign busy_eff = busy_vec;
`endif

  assign hazard      = instr_valid & ((rs1_used & busy_eff[rs1]) | (rs2_used & busy_eff[rs2]) | (rd_wen & busy_eff[rd]));
  assign issue_valid = instr_valid & ~hazard;
  assign instr_ready = ~hazard & issue_ready;
  assign fire        = instr_valid & instr_ready;
  assign set_vec     = (fire & rd_wen & (rd != '0)) ? ONE << rd : '0;
  assign clr_vec     = (wb_valid & (wb_rd != '0)) ? ONE << wb_rd : '0;
  assign busy_nxt    = (busy_vec & ~clr_vec) | set_vec;
  assign err_nxt     = wb_err | (wb_valid & (wb_rd != '0) & ~busy_vec[wb_rd]);

  // population count of the next busy vector so pending_cnt tracks busy_vec exactly
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < REG_FILE_DEPTH; i++) cnt_nxt = cnt_nxt + {{REG_FILE_ADDR_LEN{1'b0}}, busy_nxt[i]};
  end

  // scoreboard state: busy bits, their count and the sticky writeback error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_vec    <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      busy_vec    <= busy_nxt;
      pending_cnt <= cnt_nxt;
      wb_err      <= err_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n, instr_valid, instr_ready, rs1_used, rs2_used, rd_wen;
  logic        issue_valid, issue_ready, wb_valid, wb_err;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [31:0] busy_vec;
  logic [5:0]  pending_cnt;
  int          passed = 0;
  int          total = 0;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_wen(rd_wen),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy_vec(busy_vec), .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    instr_valid = 0; rs1_used = 0; rs2_used = 0; rd_wen = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_valid = 0; wb_rd = 0; issue_ready = 1;
  endtask

  task automatic issue_rd(input logic [4:0] r);
    idle();
    instr_valid = 1; rd_wen = 1; rd = r;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    check("reset_busy", busy_vec, 0);
    check("reset_cnt", {26'd0, pending_cnt}, 0);
    check("reset_err", {31'd0, wb_err}, 0);
    issue_rd(5);
    #1;
    check("free_issue_valid", {31'd0, issue_valid}, 1);
    check("free_instr_ready", {31'd0, instr_ready}, 1);
    tick(); idle();
    check("set5_busy", busy_vec, 32'h0000_0020);
    check("set5_cnt", {26'd0, pending_cnt}, 1);
    instr_valid = 1; rs1_used = 1; rs1 = 5;
    #1;
    check("raw_issue_valid", {31'd0, issue_valid}, 0);
    check("raw_instr_ready", {31'd0, instr_ready}, 0);
    rs1_used = 0; rs2_used = 1; rs2 = 5; wb_valid = 1; wb_rd = 5;
    #1;
    check("wb_same_cycle_issue", {31'd0, issue_valid}, {31'd0, BYP});
    tick();
    wb_valid = 0;
    #1;
    check("wb_next_cycle_issue", {31'd0, issue_valid}, 1);
    check("wb5_busy", busy_vec, 0);
    check("wb5_cnt", {26'd0, pending_cnt}, 0);
    tick();
    issue_rd(7);
    tick();
    check("set7_busy", busy_vec, 32'h0000_0080);
    wb_valid = 1; wb_rd = 7;
    #1;
    check("waw_bypass_issue", {31'd0, issue_valid}, {31'd0, BYP});
    tick(); idle();
    check("set_wins_busy", busy_vec, BYP ? 32'h0000_0080 : 32'h0);
    check("set_wins_cnt", {26'd0, pending_cnt}, BYP ? 1 : 0);
    check("set_wins_err", {31'd0, wb_err}, 0);
    if (BYP) begin
      wb_valid = 1; wb_rd = 7;
      tick(); idle();
    end
    issue_rd(3);
    tick();
    issue_rd(4); wb_valid = 1; wb_rd = 3;
    tick(); idle();
    check("set_clr_diff_busy", busy_vec, 32'h0000_0010);
    check("set_clr_diff_cnt", {26'd0, pending_cnt}, 1);
    wb_valid = 1; wb_rd = 4;
    tick(); idle();
    check("clr4_busy", busy_vec, 0);
    issue_rd(6); issue_ready = 0;
    #1;
    check("stall_issue_valid", {31'd0, issue_valid}, 1);
    check("stall_instr_ready", {31'd0, instr_ready}, 0);
    tick(); idle();
    check("stall_no_set", busy_vec, 0);
    issue_rd(0);
    tick(); idle();
    check("x0_set_busy", busy_vec, 0);
    wb_valid = 1; wb_rd = 0;
    tick(); idle();
    check("x0_wb_busy", busy_vec, 0);
    check("x0_wb_cnt", {26'd0, pending_cnt}, 0);
    check("x0_wb_err", {31'd0, wb_err}, 0);
    wb_valid = 1; wb_rd = 9;
    tick(); idle();
    check("wb9_err", {31'd0, wb_err}, 1);
    check("wb9_busy", busy_vec, 0);
    tick();
    check("wb9_err_sticky", {31'd0, wb_err}, 1);
    for (int r = 1; r < 32; r++) begin
      issue_rd(5'(r));
      tick();
    end
    idle();
    check("full_busy", busy_vec, 32'hFFFF_FFFE);
    check("full_cnt", {26'd0, pending_cnt}, 31);
    issue_rd(12);
    #1;
    check("full_waw_stall", {31'd0, issue_valid}, 0);
    rst_n = 0; wb_valid = 1; wb_rd = 3;
    tick();
    rst_n = 1; idle();
    check("midrst_busy", busy_vec, 0);
    check("midrst_cnt", {26'd0, pending_cnt}, 0);
    check("midrst_err", {31'd0, wb_err}, 0);
    instr_valid = 1; rs1_used = 1; rs1 = 12;
    #1;
    check("post_rst_issue", {31'd0, issue_valid}, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
